// File: rtl/mux_arb.sv
// N-channel to one registered-output arbiter: fixed priority (MODE 0) or round-robin (MODE 1).
// Defining MUX_ARB_PARITY_EN adds a registered even-parity bit (out_parity) for the loaded word.
module mux_arb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = 0,
    localparam int unsigned CW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [0:CHANNELS*WIDTH-1] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [0:WIDTH-1]          out_data,
    output logic                      out_resp,
    input  logic                      out_ready,
    output logic [CW-1:0]             out_chan
`ifdef MUX_ARB_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [0:WIDTH-1]  data_q, data_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic [CW-1:0]     grant;
    logic              found;
    logic [0:WIDTH-1]  sel_data;
    logic              take, any, xfer;
    int unsigned       idx;

    assign take = (state_q == StEmpty) || out_ready;
    assign any  = |in_valid;
    // Reset gates the handshake so nothing is accepted while reset_n is low.
    assign xfer = reset_n && take && any;

    // Search order starts at ptr+1 in round-robin mode, at channel 0 otherwise.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (MODE == 1) idx = (int'(ptr_q) + 1 + i) % CHANNELS;
            else           idx = i;
            if (!found && in_valid[CW'(idx)]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == CW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        chan_d   = chan_q;
        in_ready = '0;
        if (xfer) begin
            in_ready = {{(CHANNELS-1){1'b0}}, 1'b1} << grant;
            state_d  = StFull;
            data_d   = sel_data;
            chan_d   = grant;
            if (MODE == 1) ptr_d = grant;
        end else if (take) begin
            state_d = StEmpty;
            data_d  = '0;
            chan_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            ptr_q   <= CW'(CHANNELS - 1);
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign out_data = data_q;
    assign out_chan = chan_q;
    assign out_resp = (state_q == StFull);

`ifdef MUX_ARB_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk) begin
        if (!reset_n) parity_q <= 1'b0;
        else          parity_q <= ^data_d;
    end
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: one fixed-priority and one round-robin instance share stimulus
// and are compared against a spec-level model of grant selection and the output register.
module tb_mux_arb;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [N-1:0]     in_valid;
    logic [0:N*W-1]   in_data;
    logic             out_ready;
    logic [N-1:0]     r0, r1;
    logic [0:W-1]     d0, d1;
    logic             v0, v1;
    logic [1:0]       c0, c1;
`ifdef MUX_ARB_PARITY_EN
    logic             p0, p1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic         m_full[2];
    logic [W-1:0] m_data[2];
    int           m_chan[2];
    int           m_ptr[2];

    mux_arb #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r0), .out_data(d0), .out_resp(v0), .out_ready(out_ready), .out_chan(c0)
`ifdef MUX_ARB_PARITY_EN
        , .out_parity(p0)
`endif
    );

    mux_arb #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r1), .out_data(d1), .out_resp(v1), .out_ready(out_ready), .out_chan(c1)
`ifdef MUX_ARB_PARITY_EN
        , .out_parity(p1)
`endif
    );

    // Mode 0 scans 0..N-1; mode 1 scans from ptr+1 with wrap.
    function automatic int pick(int m);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m == 1) ? (m_ptr[m] + 1 + i) % N : i;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(int m);
        logic [N-1:0] r;
        int g;
        r = '0;
        if (!reset_n) return r;
        if (m_full[m] && !out_ready) return r;
        g = pick(m);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        logic         nf[2];
        logic [W-1:0] nd[2];
        int           nc[2];
        int           np[2];
        int           g;
        for (int m = 0; m < 2; m++) begin
            nf[m] = m_full[m]; nd[m] = m_data[m]; nc[m] = m_chan[m]; np[m] = m_ptr[m];
            if (!reset_n) begin
                nf[m] = 1'b0; nd[m] = '0; nc[m] = 0; np[m] = N - 1;
            end else if (!m_full[m] || out_ready) begin
                g = pick(m);
                if (g >= 0) begin
                    nf[m] = 1'b1; nd[m] = in_data[g*W +: W]; nc[m] = g;
                    if (m == 1) np[m] = g;
                end else begin
                    nf[m] = 1'b0; nd[m] = '0; nc[m] = 0;
                end
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            m_full[m] = nf[m]; m_data[m] = nd[m]; m_chan[m] = nc[m]; m_ptr[m] = np[m];
        end
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        rand_data();
        #1;
        n_checks++; if (r0 !== 4'b0) $display("FAIL rst_ready0 got %b want 0000", r0); else n_pass++;
        n_checks++; if (r1 !== 4'b0) $display("FAIL rst_ready1 got %b want 0000", r1); else n_pass++;
        tick();
        n_checks++;
        if (v0 !== 1'b0 || d0 !== '0 || c0 !== 2'd0)
            $display("FAIL rst_out0 got resp=%b data=%h chan=%0d want 0/0/0", v0, d0, c0);
        else n_pass++;
        n_checks++;
        if (v1 !== 1'b0 || d1 !== '0 || c1 !== 2'd0)
            $display("FAIL rst_out1 got resp=%b data=%h chan=%0d want 0/0/0", v1, d1, c1);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_fixed_priority();
        logic [W-1:0] want;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        rand_data();
        want = in_data[1*W +: W];
        #1;
        n_checks++; if (r0 !== 4'b0010) $display("FAIL fp_ready got %b want 0010", r0); else n_pass++;
        tick();
        n_checks++;
        if (v0 !== 1'b1 || c0 !== 2'd1 || d0 !== want)
            $display("FAIL fp_out got resp=%b chan=%0d data=%h want 1/1/%h", v0, c0, d0, want);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            tick();
            n_checks++;
            if (c1 !== 2'(seq[i]) || v1 !== 1'b1)
                $display("FAIL rr_seq%0d got chan=%0d resp=%b want %0d/1", i, c1, v1, seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held, nxt;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        rand_data();
        held = in_data[0 +: W];
        tick();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            n_checks++;
            if (r0 !== 4'b0 || r1 !== 4'b0)
                $display("FAIL stall_ready%0d got %b/%b want 0000", i, r0, r1);
            else n_pass++;
            tick();
            n_checks++;
            if (d0 !== held || v0 !== 1'b1)
                $display("FAIL stall_hold%0d got %h resp=%b want %h/1", i, d0, v0, held);
            else n_pass++;
        end
        out_ready = 1'b1;
        rand_data();
        nxt = in_data[0 +: W];
        #1;
        n_checks++; if (r0 !== 4'b0001) $display("FAIL stall_rel got %b want 0001", r0); else n_pass++;
        tick();
        n_checks++;
        if (d0 !== nxt || c0 !== 2'd0) $display("FAIL stall_load got %h/%0d want %h/0", d0, c0, nxt);
        else n_pass++;
    endtask

    task automatic test_drain();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        rand_data();
        tick();
        in_valid = 4'b0;
        tick();
        n_checks++;
        if (v0 !== 1'b0 || d0 !== '0 || c0 !== 2'd0 || v1 !== 1'b0 || d1 !== '0 || c1 !== 2'd0)
            $display("FAIL drain got resp=%b/%b data=%h/%h chan=%0d/%0d want zeros",
                     v0, v1, d0, d1, c0, c1);
        else n_pass++;
    endtask

    task automatic test_reset_full();
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        in_data[0 +: W] = 32'hDEADBEEF;
        tick();
        n_checks++; if (d0 !== 32'hDEADBEEF) $display("FAIL rf_load got %h want deadbeef", d0);
        else n_pass++;
        do_reset();
        n_checks++;
        if (v0 !== 1'b0 || d0 !== '0 || v1 !== 1'b0 || d1 !== '0)
            $display("FAIL rf_clear got resp=%b/%b data=%h/%h want 0", v0, v1, d0, d1);
        else n_pass++;
        in_valid = 4'hF;
        tick();
        n_checks++; if (c1 !== 2'd0) $display("FAIL rf_first got %0d want 0", c1); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            reset_n   = ($urandom_range(0, 49) != 0);
            rand_data();
            #1;
            n_checks++;
            if (r0 !== exp_ready(0)) $display("FAIL rnd_ready0 got %b want %b", r0, exp_ready(0));
            else n_pass++;
            n_checks++;
            if (r1 !== exp_ready(1)) $display("FAIL rnd_ready1 got %b want %b", r1, exp_ready(1));
            else n_pass++;
            tick();
            n_checks++;
            if (v0 !== m_full[0] || d0 !== m_data[0] || c0 !== 2'(m_chan[0]))
                $display("FAIL rnd_out0 got %b/%h/%0d want %b/%h/%0d",
                         v0, d0, c0, m_full[0], m_data[0], m_chan[0]);
            else n_pass++;
            n_checks++;
            if (v1 !== m_full[1] || d1 !== m_data[1] || c1 !== 2'(m_chan[1]))
                $display("FAIL rnd_out1 got %b/%h/%0d want %b/%h/%0d",
                         v1, d1, c1, m_full[1], m_data[1], m_chan[1]);
            else n_pass++;
`ifdef MUX_ARB_PARITY_EN
            n_checks++;
            if (p0 !== ^m_data[0]) $display("FAIL rnd_par got %b want %b", p0, ^m_data[0]);
            else n_pass++;
`endif
        end
        reset_n = 1'b1;
    endtask

`ifdef MUX_ARB_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        in_data[0 +: W] = 32'h00000007;
        tick();
        n_checks++; if (p0 !== 1'b1) $display("FAIL par7 got %b want 1", p0); else n_pass++;
        in_data[0 +: W] = 32'h00000003;
        tick();
        n_checks++; if (p0 !== 1'b0) $display("FAIL par3 got %b want 0", p0); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_stall();
        test_drain();
        test_reset_full();
`ifdef MUX_ARB_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
